de_inst_queue: RTL and testbench
================================

DE_INST_QUEUE -- requirements
Module: de_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-002 SHALL have parameter EXC_W, default 5: exception-code width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_p, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port empty, input, 1: pipeline flush; discards all entries.
REQ-006 SHALL have port redirect, input, 1: taken branch/jump leaving DE; keeps delay-slot entry only.
REQ-007 SHALL have port IF_ready, input, 1: IF offers an entry.
REQ-008 SHALL have port inst_in, input, 32: offered instruction.
REQ-009 SHALL have port IF_PC, input, 32: offered PC.
REQ-010 SHALL have port exccode_in, input, EXC_W: offered IF exception code.
REQ-011 SHALL have port DQ_enable, output, 1: queue can accept an entry.
REQ-012 SHALL have port DQ_ready, output, 1: head entry valid.
REQ-013 SHALL have port DE_enable, input, 1: DE accepts the head.
REQ-014 SHALL have port inst_out, output, 32: head instruction.
REQ-015 SHALL have port PC_out, output, 32: head PC.
REQ-016 SHALL have port exccode_out, output, EXC_W: head exception code.
REQ-017 SHALL have port count, output, log2(DEPTH)+1: number of stored entries.

Function
REQ-018 push = IF_ready && DQ_enable; pop = DQ_ready && DE_enable.
REQ-019 DQ_enable SHALL be (count != DEPTH) || pop.
REQ-020 Storage SHALL be a circular buffer; read and write pointers wrap modulo DEPTH.
REQ-021 Entries SHALL leave in arrival order; {inst, PC, exccode} SHALL stay together.
REQ-022 Without bypass, a pushed entry SHALL first appear at the head one cycle after the push.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged, including when count is DEPTH or 1.
REQ-024 With count==0, DQ_ready SHALL be 0 and the output values are don't-care.
REQ-025 empty=1 SHALL set count, read pointer and write pointer to 0 on the next edge and discard any push in that cycle.
REQ-026 redirect=1 with empty=0: of the stored entries not popped this cycle plus any push, the single oldest SHALL be kept as head and all others dropped, giving count 1 or 0 next cycle.
REQ-027 Priority SHALL be rst_p > empty > redirect > normal push/pop.
REQ-028 Outputs SHALL hold steady while DQ_ready=1 and DE_enable=0.

Reset
REQ-029 rst_p SHALL clear count and both pointers, giving DQ_ready=0 and DQ_enable=1 in the next cycle.
REQ-030 Entry storage SHALL NOT require reset.
REQ-031 Reset mid-traffic SHALL discard all entries and ignore any push in that cycle.

Configuration
REQ-032 Macro DE_INST_QUEUE_BYPASS_EN SHALL, when defined, enable bypass.
REQ-033 With bypass and count==0: DQ_ready = IF_ready, outputs equal the inputs combinationally, and a push with DE_enable=1 passes through without being stored.
REQ-034 Without the macro, minimum latency SHALL be one cycle and no input-to-output combinational path SHALL exist.
REQ-035 Bypassed entries SHALL count as popped under REQ-026.

Verification
REQ-036 After reset, push 0x24010001..0x24010004 with PC 0xBFC00000 +4n and DE_enable=0 -> count=4, DQ_enable=0; then DE_enable=1 -> the four entries emerge in order over 4 cycles.
REQ-037 With count=4, IF_ready=1 and DE_enable=1 for 10 cycles -> count stays 4, PCs increase by 4 each cycle across pointer wrap, and no entry is lost.
REQ-038 With count=3 and redirect=1 with no pop -> next cycle count=1 and the head is the oldest entry (delay slot); with redirect=1 and pop -> count=0.
REQ-039 With count=2 and empty=1 together with redirect=1 and IF_ready=1 -> next cycle count=0 and DQ_ready=0.
REQ-040 Push with exccode_in=5'h04 -> same entry exits with exccode_out=5'h04 and matching PC.
REQ-041 With bypass defined, count=0, IF_ready=1, DE_enable=1 -> DQ_ready=1 in the same cycle and count stays 0; without the macro, DQ_ready=1 one cycle later.

Source files
------------

// File: rtl/de_inst_queue.sv
// de_inst_queue: decode-stage instruction queue between IF and DE.
// Circular buffer of {inst, PC, exccode} entries with flush (empty) and
// branch redirect handling that keeps only the delay-slot entry.
// Optional feature: define DE_INST_QUEUE_BYPASS_EN to let an entry offered
// to an empty queue reach the head combinationally in the same cycle.
module de_inst_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_p,
  input  logic                       empty,
  input  logic                       redirect,
  input  logic                       IF_ready,
  input  logic [31:0]                inst_in,
  input  logic [31:0]                IF_PC,
  input  logic [EXC_W-1:0]           exccode_in,
  output logic                       DQ_enable,
  output logic                       DQ_ready,
  input  logic                       DE_enable,
  output logic [31:0]                inst_out,
  output logic [31:0]                PC_out,
  output logic [EXC_W-1:0]           exccode_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 64 + EXC_W;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] rd_ptr_n, wr_ptr_n, rd_next;
  logic [AW:0]   count_n, remain;
  logic [EW-1:0] head_ent, in_ent;
  logic          is_empty, push, pop, push_mem, pop_mem, wr_en;

  // Handshake and head selection; push_mem/pop_mem separate real storage
  // traffic from an entry that only passes through an empty queue.
  always_comb begin
    is_empty = (count == '0);
    in_ent   = {inst_in, IF_PC, exccode_in};
    head_ent = mem[rd_ptr];
`ifdef DE_INST_QUEUE_BYPASS_EN
    DQ_ready = !is_empty || IF_ready;
    {inst_out, PC_out, exccode_out} = is_empty ? in_ent : head_ent;
`else
    DQ_ready = !is_empty;
    {inst_out, PC_out, exccode_out} = head_ent;
`endif
    pop       = DQ_ready && DE_enable;
    DQ_enable = (count != FULL_CNT) || pop;
    push      = IF_ready && DQ_enable;
    pop_mem   = pop && !is_empty;
    push_mem  = push && !(is_empty && pop);
  end

  // Next pointers/count: flush beats redirect, redirect keeps the oldest
  // surviving entry (stored remainder first, else the incoming push).
  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    wr_en    = 1'b0;
    rd_next  = pop_mem ? rd_ptr + ONE_PTR : rd_ptr;
    remain   = count - (pop_mem ? ONE_CNT : '0);
    if (empty) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else if (redirect) begin
      if (remain != '0) begin
        rd_ptr_n = rd_next;
        wr_ptr_n = rd_next + ONE_PTR;
        count_n  = ONE_CNT;
      end else if (push_mem) begin
        wr_en    = 1'b1;
        rd_ptr_n = wr_ptr;
        wr_ptr_n = wr_ptr + ONE_PTR;
        count_n  = ONE_CNT;
      end else begin
        rd_ptr_n = rd_next;
        wr_ptr_n = rd_next;
        count_n  = '0;
      end
    end else begin
      wr_en    = push_mem;
      rd_ptr_n = rd_next;
      wr_ptr_n = push_mem ? wr_ptr + ONE_PTR : wr_ptr;
      count_n  = count + (push_mem ? ONE_CNT : '0) - (pop_mem ? ONE_CNT : '0);
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
    end
  end

  // Entry storage needs no reset; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst_p) begin
      mem[wr_ptr] <= in_ent;
    end
  end

endmodule

// File: tb/tb_de_inst_queue.sv
// tb_de_inst_queue: self-checking bench for de_inst_queue using a
// queue-based reference model plus directed literal checks.
// Honours DE_INST_QUEUE_BYPASS_EN the same way as the design.
module tb_de_inst_queue;

  localparam int DEPTH = 4;
  localparam int EXC_W = 5;
`ifdef DE_INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_p = 1'b0;
  logic             empty = 1'b0;
  logic             redirect = 1'b0;
  logic             IF_ready = 1'b0;
  logic [31:0]      inst_in = '0;
  logic [31:0]      IF_PC = '0;
  logic [EXC_W-1:0] exccode_in = '0;
  logic             DE_enable = 1'b0;
  logic             DQ_enable, DQ_ready;
  logic [31:0]      inst_out, PC_out;
  logic [EXC_W-1:0] exccode_out;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t q[$];
  ent_t head;
  bit   model_valid = 1'b0;
  bit   m_ready, m_pop, m_en, m_push;

  de_inst_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst_p(rst_p), .empty(empty), .redirect(redirect),
    .IF_ready(IF_ready), .inst_in(inst_in), .IF_PC(IF_PC),
    .exccode_in(exccode_in), .DQ_enable(DQ_enable), .DQ_ready(DQ_ready),
    .DE_enable(DE_enable), .inst_out(inst_out), .PC_out(PC_out),
    .exccode_out(exccode_out), .count(count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic apply_stimulus(input logic ifr, input logic [31:0] ins, input logic [31:0] pc,
                                input logic [EXC_W-1:0] exc, input logic de, input logic red,
                                input logic emp, input logic rst);
    @(posedge clk);
    #1;
    IF_ready = ifr; inst_in = ins; IF_PC = pc; exccode_in = exc;
    DE_enable = de; redirect = red; empty = emp; rst_p = rst;
    #2;
  endtask

  // Reference model: compare outputs mid-cycle, then advance by the rules
  // (append push, remove popped front, redirect truncates to oldest).
  always @(negedge clk) begin
    m_ready = (q.size() != 0) || (BYP && IF_ready);
    m_pop   = m_ready && DE_enable;
    m_en    = (q.size() != DEPTH) || m_pop;
    m_push  = IF_ready && m_en;
    if (model_valid) begin
      check_output("count", 64'(count), 64'(q.size()));
      check_output("DQ_ready", 64'(DQ_ready), 64'(m_ready));
      check_output("DQ_enable", 64'(DQ_enable), 64'(m_en));
      if (m_ready) begin
        head = (q.size() != 0) ? q[0] : ent_t'{inst_in, IF_PC, exccode_in};
        check_output("inst_out", 64'(inst_out), 64'(head.inst));
        check_output("PC_out", 64'(PC_out), 64'(head.pc));
        check_output("exccode_out", 64'(exccode_out), 64'(head.exc));
      end
    end
    if (rst_p) begin
      q.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (empty) begin
        q.delete();
      end else begin
        if (m_push) q.push_back(ent_t'{inst_in, IF_PC, exccode_in});
        if (m_pop) void'(q.pop_front());
        if (redirect) while (q.size() > 1) void'(q.pop_back());
      end
    end
  end

  initial begin
    logic [31:0] pc0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_DQ_ready", 64'(DQ_ready), 64'd0);
    check_output("rst_DQ_enable", 64'(DQ_enable), 64'd1);

    // Fill four entries with DE stalled, then drain in order.
    for (int n = 0; n < 4; n++)
      apply_stimulus(1, 32'h24010001 + n, 32'hBFC00000 + 4*n, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("full_count", 64'(count), 64'd4);
    check_output("full_DQ_enable", 64'(DQ_enable), 64'd0);
    check_output("full_head", 64'(inst_out), 64'h24010001);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
      check_output("drain_inst", 64'(inst_out), 64'h24010001 + k);
      check_output("drain_pc", 64'(PC_out), 64'hBFC00000 + 4*k);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("drained_count", 64'(count), 64'd0);
    check_output("drained_ready", 64'(DQ_ready), 64'd0);

    // Full queue streaming through pointer wrap.
    pc0 = 32'hBFC00100;
    for (int n = 0; n < 4; n++)
      apply_stimulus(1, 32'h20000000 + n, pc0 + 4*n, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1, 32'h20000004 + k, pc0 + 16 + 4*k, 0, 1, 0, 0, 0);
      check_output("stream_count", 64'(count), 64'd4);
      check_output("stream_pc", 64'(PC_out), 64'(pc0 + 4*k));
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Redirect with three stored, no pop: keep the delay slot only.
    for (int n = 0; n < 3; n++)
      apply_stimulus(1, 32'h30000000 + n, 32'hBFC00200 + 4*n, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("pre_redirect_count", 64'(count), 64'd3);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("redirect_count", 64'(count), 64'd1);
    check_output("redirect_head", 64'(inst_out), 64'h30000000);
    check_output("redirect_pc", 64'(PC_out), 64'hBFC00200);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("redirect_pop_count", 64'(count), 64'd0);

    // Flush wins over redirect and push.
    for (int n = 0; n < 2; n++)
      apply_stimulus(1, 32'h40000000 + n, 32'hBFC00300 + 4*n, 0, 0, 0, 0, 0);
    apply_stimulus(1, 32'h40000002, 32'hBFC00308, 0, 0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("flush_count", 64'(count), 64'd0);
    check_output("flush_ready", 64'(DQ_ready), 64'd0);

    // Exception code travels with its entry.
    apply_stimulus(1, 32'h00000000, 32'hBFC00380, 5'h04, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("exc_code", 64'(exccode_out), 64'h04);
    check_output("exc_pc", 64'(PC_out), 64'hBFC00380);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Minimum latency from an empty queue.
    apply_stimulus(1, 32'h50000000, 32'hBFC00400, 0, 1, 0, 0, 0);
    check_output("lat_same_ready", 64'(DQ_ready), 64'(BYP));
    check_output("lat_same_count", 64'(count), 64'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("lat_next_ready", 64'(DQ_ready), 64'(!BYP));
    check_output("lat_next_count", 64'(count), BYP ? 64'd0 : 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 9) < 7, $urandom, $urandom, EXC_W'($urandom),
                     $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
